// File: rtl/router_pkg.sv
// Shared types and constants for the router packet transmitter.
// The header byte carries the payload length above the destination address.
package router_pkg;

    localparam int MAX_PAYLOAD  = 63;
    localparam int ADDR_W       = 2;
    localparam int DATA_W       = 8;
    localparam int LEN_W        = DATA_W - ADDR_W;
    localparam int BUF_DEPTH    = 64;
    localparam int PTR_W        = 6;

    localparam int HDR_ADDR_LSB = 0;
    localparam int HDR_ADDR_MSB = ADDR_W - 1;
    localparam int HDR_LEN_LSB  = ADDR_W;
    localparam int HDR_LEN_MSB  = DATA_W - 1;

    localparam logic [ADDR_W-1:0] ILLEGAL_ADDR = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HEADER,
        S_PAYLOAD,
        S_PARITY,
        S_DONE
    } state_t;

    function automatic logic [DATA_W-1:0] make_header(
        input logic [LEN_W-1:0]  len,
        input logic [ADDR_W-1:0] addr
    );
        logic [DATA_W-1:0] hdr;
        hdr = '0;
        hdr[HDR_LEN_MSB:HDR_LEN_LSB]   = len;
        hdr[HDR_ADDR_MSB:HDR_ADDR_LSB] = addr;
        return hdr;
    endfunction

endpackage

// File: rtl/tx_payload_buf.sv
// Payload store for one packet: 64x8 array, synchronous write at the fill
// pointer, combinational read at the drain index. Only the pointers reset.
module tx_payload_buf
    import router_pkg::*;
(
    input  logic              clock,
    input  logic              resetn,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_inc,
    input  logic              clear,
    output logic [PTR_W-1:0]  count,
    output logic [PTR_W-1:0]  rd_idx,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem_reg [BUF_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_reg;
    logic [PTR_W-1:0]  rd_ptr_reg;

    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem_reg[wr_ptr_reg] <= wr_data;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else if (clear) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (rd_inc) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
        end
    end

    assign count   = wr_ptr_reg;
    assign rd_idx  = rd_ptr_reg;
    assign rd_data = mem_reg[rd_ptr_reg];

endmodule

// File: rtl/router_pkt_tx.sv
// Packet transmitter: buffers payload bytes, then sends header, payload and
// an XOR parity byte to the router, stalling on busy.
module router_pkt_tx
    import router_pkg::*;
(
    input  logic              clock,
    input  logic              resetn,
    input  logic              buf_wr,
    input  logic [DATA_W-1:0] buf_wdata,
    input  logic              start,
    input  logic [ADDR_W-1:0] dest_addr,
    input  logic              busy,
    input  logic              err,
    output logic              pkt_valid,
    output logic [DATA_W-1:0] data_in,
    output logic              tx_ready,
    output logic [PTR_W-1:0]  buf_count,
    output logic              tx_done,
    output logic              cfg_err,
    output logic              err_seen
);

    state_t            state_reg;
    logic              valid_reg;
    logic [DATA_W-1:0] data_reg;
    logic [DATA_W-1:0] acc_reg;
    logic              done_reg;
    logic              cfg_err_reg;
    logic              err_seen_reg;
    logic [1:0]        err_win_reg;

    logic [PTR_W-1:0]  count;
    logic [PTR_W-1:0]  rd_idx;
    logic [DATA_W-1:0] rd_data;

    logic              wr_accept;
    logic [PTR_W-1:0]  eff_count;
    logic              start_legal;
    logic [DATA_W-1:0] header_next;
    logic              more_bytes;
    logic              rd_inc;
    logic              buf_clear;
    logic              err_window;

    // A write in the same cycle as start is counted into the header length.
    assign wr_accept   = (state_reg == S_IDLE) && buf_wr
                         && (count != PTR_W'(MAX_PAYLOAD));
    assign eff_count   = count + PTR_W'(wr_accept);
    assign start_legal = (eff_count != '0) && (dest_addr != ILLEGAL_ADDR);
    assign header_next = make_header(eff_count, dest_addr);

    assign more_bytes  = (rd_idx != count);
    assign rd_inc      = !busy && ((state_reg == S_HEADER)
                         || ((state_reg == S_PAYLOAD) && more_bytes));
    assign buf_clear   = (state_reg == S_DONE);

    // Router errors are tracked from parity through two cycles past done.
    assign err_window  = (state_reg == S_PARITY) || (state_reg == S_DONE)
                         || ((state_reg == S_IDLE) && (err_win_reg != 2'd0));

    tx_payload_buf u_buf (
        .clock   (clock),
        .resetn  (resetn),
        .wr_en   (wr_accept),
        .wr_data (buf_wdata),
        .rd_inc  (rd_inc),
        .clear   (buf_clear),
        .count   (count),
        .rd_idx  (rd_idx),
        .rd_data (rd_data)
    );

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_reg    <= S_IDLE;
            valid_reg    <= 1'b0;
            data_reg     <= '0;
            acc_reg      <= '0;
            done_reg     <= 1'b0;
            cfg_err_reg  <= 1'b0;
            err_seen_reg <= 1'b0;
            err_win_reg  <= 2'd0;
        end else begin
            cfg_err_reg <= 1'b0;
            done_reg    <= 1'b0;
            if (err && err_window) begin
                err_seen_reg <= 1'b1;
            end
            if (err_win_reg != 2'd0) begin
                err_win_reg <= err_win_reg - 2'd1;
            end
            case (state_reg)
                S_IDLE: begin
                    if (start) begin
                        if (start_legal) begin
                            state_reg    <= S_HEADER;
                            data_reg     <= header_next;
                            valid_reg    <= 1'b1;
                            acc_reg      <= header_next;
                            err_seen_reg <= 1'b0;
                            err_win_reg  <= 2'd0;
                        end else begin
                            cfg_err_reg <= 1'b1;
                        end
                    end
                end
                S_HEADER: begin
                    if (!busy) begin
                        state_reg <= S_PAYLOAD;
                        data_reg  <= rd_data;
                    end
                end
                S_PAYLOAD: begin
                    if (!busy) begin
                        acc_reg <= acc_reg ^ data_reg;
                        if (more_bytes) begin
                            data_reg <= rd_data;
                        end else begin
                            state_reg <= S_PARITY;
                            valid_reg <= 1'b0;
                            data_reg  <= acc_reg ^ data_reg;
                        end
                    end
                end
                S_PARITY: begin
                    if (!busy) begin
                        state_reg <= S_DONE;
                        data_reg  <= '0;
                        done_reg  <= 1'b1;
                    end
                end
                S_DONE: begin
                    state_reg   <= S_IDLE;
                    err_win_reg <= 2'd2;
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    assign pkt_valid = valid_reg;
    assign data_in   = data_reg;
    assign tx_ready  = (state_reg == S_IDLE);
    assign buf_count = count;
    assign tx_done   = done_reg;
    assign cfg_err   = cfg_err_reg;
    assign err_seen  = err_seen_reg;

endmodule
